// File: rtl/rgb_stream_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rgb_stream_frame_arbiter
// Brief    : Two-source, frame-granular round-robin AXI4-Stream video arbiter
//            with a zero-latency data path. Optional ARB_STATS_EN adds
//            per-source completed-frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_stream_frame_arbiter #(
  parameter int DATA_WIDTH   = 24,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                  StreamClk,
  input  logic                  sStreamReset_n,
  input  logic                  s0_axis_video_tvalid,
  input  logic [DATA_WIDTH-1:0] s0_axis_video_tdata,
  input  logic                  s0_axis_video_tlast,
  input  logic                  s0_axis_video_tuser,
  output logic                  s0_axis_video_tready,
  input  logic                  s1_axis_video_tvalid,
  input  logic [DATA_WIDTH-1:0] s1_axis_video_tdata,
  input  logic                  s1_axis_video_tlast,
  input  logic                  s1_axis_video_tuser,
  output logic                  s1_axis_video_tready,
  output logic                  m_axis_video_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tlast,
  output logic                  m_axis_video_tuser,
  input  logic                  m_axis_video_tready,
`ifdef ARB_STATS_EN
  output logic [15:0]           frames0,
  output logic [15:0]           frames1,
`endif
  output logic                  busy,
  output logic                  grant_src,
  output logic                  frame_done,
  output logic                  sof_err
);

  localparam int c_CNT_W = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_LINE = c_CNT_W'(IMAGE_HEIGHT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_GRANT0 = 2'd1;
  localparam logic [1:0] c_GRANT1 = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [c_CNT_W-1:0]    r_line_cnt;
  logic                  r_rr_last;
  logic                  r_first;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_granted;
  logic                  w_sel;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic                  w_src_user;
  logic                  w_accept;
  logic                  w_restart;
  logic                  w_eol;
  logic                  w_frame_end;

  // A held SOF beat is the request; it is not consumed until the grant starts.
  assign w_req0      = s0_axis_video_tvalid & s0_axis_video_tuser;
  assign w_req1      = s1_axis_video_tvalid & s1_axis_video_tuser;
  assign w_granted   = (r_state == c_GRANT0) | (r_state == c_GRANT1);
  assign w_sel       = (r_state == c_GRANT1);
  assign w_src_valid = w_sel ? s1_axis_video_tvalid : s0_axis_video_tvalid;
  assign w_src_last  = w_sel ? s1_axis_video_tlast  : s0_axis_video_tlast;
  assign w_src_user  = w_sel ? s1_axis_video_tuser  : s0_axis_video_tuser;
  assign w_accept    = w_granted & w_src_valid & m_axis_video_tready;
  // A mid-grant SOF restarts the frame and overrides any EOL on the same beat.
  assign w_restart   = w_accept & w_src_user & ~r_first;
  assign w_eol       = w_accept & w_src_last & ~w_restart;
  assign w_frame_end = w_eol & (r_line_cnt == c_LAST_LINE);

  always_ff @(posedge StreamClk or negedge sStreamReset_n) begin
    if (!sStreamReset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_req0 && (!w_req1 || r_rr_last)) begin
          w_next_state = c_GRANT0;
        end else if (w_req1) begin
          w_next_state = c_GRANT1;
        end
      end
      c_GRANT0, c_GRANT1: begin
        if (w_frame_end) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Idle-state junk draining is gated by reset so tready drops the instant reset asserts.
  always_comb begin
    m_axis_video_tvalid  = 1'b0;
    m_axis_video_tdata   = '0;
    m_axis_video_tlast   = 1'b0;
    m_axis_video_tuser   = 1'b0;
    s0_axis_video_tready = 1'b0;
    s1_axis_video_tready = 1'b0;
    case (r_state)
      c_IDLE: begin
        s0_axis_video_tready = sStreamReset_n & s0_axis_video_tvalid & ~s0_axis_video_tuser;
        s1_axis_video_tready = sStreamReset_n & s1_axis_video_tvalid & ~s1_axis_video_tuser;
      end
      c_GRANT0: begin
        m_axis_video_tvalid  = s0_axis_video_tvalid;
        m_axis_video_tdata   = s0_axis_video_tdata;
        m_axis_video_tlast   = s0_axis_video_tlast;
        m_axis_video_tuser   = s0_axis_video_tuser;
        s0_axis_video_tready = m_axis_video_tready;
      end
      c_GRANT1: begin
        m_axis_video_tvalid  = s1_axis_video_tvalid;
        m_axis_video_tdata   = s1_axis_video_tdata;
        m_axis_video_tlast   = s1_axis_video_tlast;
        m_axis_video_tuser   = s1_axis_video_tuser;
        s1_axis_video_tready = m_axis_video_tready;
      end
      default: ;
    endcase
    busy       = w_granted;
    grant_src  = w_sel;
    frame_done = w_frame_end;
    sof_err    = w_restart;
  end

  always_ff @(posedge StreamClk or negedge sStreamReset_n) begin
    if (!sStreamReset_n) begin
      r_line_cnt <= '0;
      r_rr_last  <= 1'b1;
      r_first    <= 1'b1;
    end else begin
      if (w_restart || w_frame_end) begin
        r_line_cnt <= '0;
      end else if (w_eol) begin
        r_line_cnt <= r_line_cnt + c_CNT_W'(1);
      end
      if (w_frame_end) begin
        r_rr_last <= w_sel;
      end
      if (!w_granted) begin
        r_first <= 1'b1;
      end else if (w_accept) begin
        r_first <= 1'b0;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_frames0;
  logic [15:0] r_frames1;

  always_ff @(posedge StreamClk or negedge sStreamReset_n) begin
    if (!sStreamReset_n) begin
      r_frames0 <= '0;
      r_frames1 <= '0;
    end else if (w_frame_end) begin
      if (w_sel) begin
        r_frames1 <= r_frames1 + 16'd1;
      end else begin
        r_frames0 <= r_frames0 + 16'd1;
      end
    end
  end

  assign frames0 = r_frames0;
  assign frames1 = r_frames1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_stream_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_stream_frame_arbiter
// Brief    : Directed bench with a frame-level reference model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_stream_frame_arbiter;

  localparam int DW = 24;
  localparam int H  = 4;
  localparam int W  = 8;

  logic          StreamClk;
  logic          sStreamReset_n;
  logic          s0_tvalid, s0_tlast, s0_tuser, s0_tready;
  logic [DW-1:0] s0_tdata;
  logic          s1_tvalid, s1_tlast, s1_tuser, s1_tready;
  logic [DW-1:0] s1_tdata;
  logic          m_tvalid, m_tlast, m_tuser, m_tready;
  logic [DW-1:0] m_tdata;
  logic          busy, grant_src, frame_done, sof_err;
`ifdef ARB_STATS_EN
  logic [15:0]   frames0, frames1;
`endif

  rgb_stream_frame_arbiter #(.DATA_WIDTH(DW), .IMAGE_HEIGHT(H)) dut (
    .StreamClk           (StreamClk),
    .sStreamReset_n      (sStreamReset_n),
    .s0_axis_video_tvalid(s0_tvalid),
    .s0_axis_video_tdata (s0_tdata),
    .s0_axis_video_tlast (s0_tlast),
    .s0_axis_video_tuser (s0_tuser),
    .s0_axis_video_tready(s0_tready),
    .s1_axis_video_tvalid(s1_tvalid),
    .s1_axis_video_tdata (s1_tdata),
    .s1_axis_video_tlast (s1_tlast),
    .s1_axis_video_tuser (s1_tuser),
    .s1_axis_video_tready(s1_tready),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tlast  (m_tlast),
    .m_axis_video_tuser  (m_tuser),
    .m_axis_video_tready (m_tready),
`ifdef ARB_STATS_EN
    .frames0             (frames0),
    .frames1             (frames1),
`endif
    .busy                (busy),
    .grant_src           (grant_src),
    .frame_done          (frame_done),
    .sof_err             (sof_err)
  );

  typedef struct packed {logic [DW-1:0] d; logic l; logic u;} beat_t;
  typedef struct packed {logic [DW-1:0] d; logic l; logic u; logic src; logic done; logic err;} exp_t;

  beat_t drv0[$], drv1[$], raw0[$], raw1[$];
  exp_t  exp_q[$], p0[$], p1[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    m_rr_last = 1'b1;
  int    ready_mode = 0;
  int    acc_cnt = 0;
  int    done_at[$];
  int    err_at[$];
  bit    done_src[$];

  initial begin
    StreamClk = 1'b0;
    forever #5 StreamClk = ~StreamClk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Source drivers and sink ready: inputs change on the falling edge.
  initial begin
    bit hs0, hs1;
    s0_tvalid = 0; s0_tdata = '0; s0_tlast = 0; s0_tuser = 0;
    s1_tvalid = 0; s1_tdata = '0; s1_tlast = 0; s1_tuser = 0;
    m_tready  = 0;
    forever begin
      @(negedge StreamClk);
      if (drv0.size() > 0) begin
        s0_tvalid = 1; s0_tdata = drv0[0].d; s0_tlast = drv0[0].l; s0_tuser = drv0[0].u;
      end else begin
        s0_tvalid = 0; s0_tdata = '0; s0_tlast = 0; s0_tuser = 0;
      end
      if (drv1.size() > 0) begin
        s1_tvalid = 1; s1_tdata = drv1[0].d; s1_tlast = drv1[0].l; s1_tuser = drv1[0].u;
      end else begin
        s1_tvalid = 0; s1_tdata = '0; s1_tlast = 0; s1_tuser = 0;
      end
      m_tready = (ready_mode == 0) ? 1'b1 : ~m_tready;
      #3;
      hs0 = s0_tvalid & s0_tready;
      hs1 = s1_tvalid & s1_tready;
      @(posedge StreamClk);
      if (hs0 && sStreamReset_n && drv0.size() > 0) void'(drv0.pop_front());
      if (hs1 && sStreamReset_n && drv1.size() > 0) void'(drv1.pop_front());
    end
  end

  // Reference model: split each source stream into frames by SOF/EOL rules.
  task automatic parse(input bit s);
    beat_t r[$];
    exp_t  o[$];
    exp_t  e;
    bit    inf   = 0;
    bit    first = 0;
    int    lines = 0;
    if (s) r = raw1; else r = raw0;
    foreach (r[i]) begin
      if (!inf && r[i].u) begin inf = 1; first = 1; lines = 0; end
      if (inf) begin
        e.d = r[i].d; e.l = r[i].l; e.u = r[i].u; e.src = s; e.done = 0; e.err = 0;
        if (r[i].u && !first) begin
          e.err = 1; lines = 0;
        end else if (r[i].l) begin
          if (lines == H - 1) begin e.done = 1; inf = 0; lines = 0; end
          else lines++;
        end
        first = 0;
        o.push_back(e);
      end
    end
    if (s) begin p1 = o; raw1.delete(); end
    else   begin p0 = o; raw0.delete(); end
  endtask

  // Whole frames are interleaved round-robin; a lone requester always wins.
  task automatic build_exp();
    parse(0);
    parse(1);
    while (p0.size() > 0 || p1.size() > 0) begin
      bit   pick;
      exp_t e;
      if (p0.size() > 0 && p1.size() > 0) pick = ~m_rr_last;
      else pick = (p1.size() > 0);
      while (1) begin
        if (pick) e = p1.pop_front(); else e = p0.pop_front();
        exp_q.push_back(e);
        if (e.done || (pick ? p1.size() : p0.size()) == 0) break;
      end
      m_rr_last = pick;
    end
  endtask

  task automatic add_frame(input bit s, input int tag, input int nbeats, input int restart_at);
    for (int i = 0; i < nbeats; i++) begin
      beat_t b;
      b.d = {tag[7:0], 8'(i / W), 8'(i)};
      b.u = (i == 0) || (i == restart_at - 1);
      b.l = (i % W == W - 1);
      if (s) begin drv1.push_back(b); raw1.push_back(b); end
      else   begin drv0.push_back(b); raw0.push_back(b); end
    end
  endtask

  task automatic add_junk(input bit s, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = 24'hEE0000 | 24'(i); b.u = 0; b.l = 0;
      if (s) begin drv1.push_back(b); raw1.push_back(b); end
      else   begin drv0.push_back(b); raw0.push_back(b); end
    end
  endtask

  task automatic clear_log();
    acc_cnt = 0;
    done_at.delete();
    err_at.delete();
    done_src.delete();
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() > 0 || drv0.size() > 0 || drv1.size() > 0) && cyc < 3000) begin
      @(negedge StreamClk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), cyc);
    end
    repeat (3) @(negedge StreamClk);
    #2;
    check({name, "_idle_after"}, busy, 0);
  endtask

  task automatic do_reset();
    sStreamReset_n = 0;
    repeat (2) @(negedge StreamClk);
    sStreamReset_n = 1;
    exp_q.delete();
    m_rr_last = 1'b1;
  endtask

  // Scoreboard and per-cycle protocol rules, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge StreamClk);
      #3;
      if (sStreamReset_n) begin
        if (busy) begin
          if (grant_src) begin
            check("s1_tready_follows", s1_tready, m_tready);
            check("s0_tready_blocked", s0_tready, 0);
            check("m_tvalid_from_s1", m_tvalid, s1_tvalid);
          end else begin
            check("s0_tready_follows", s0_tready, m_tready);
            check("s1_tready_blocked", s1_tready, 0);
            check("m_tvalid_from_s0", m_tvalid, s0_tvalid);
          end
        end else begin
          check("idle_m_tvalid", m_tvalid, 0);
          check("idle_s0_tready", s0_tready, s0_tvalid & ~s0_tuser);
          check("idle_s1_tready", s1_tready, s1_tvalid & ~s1_tuser);
        end
        if (m_tvalid && m_tready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("m_tdata", m_tdata, e.d);
            check("m_tlast", m_tlast, e.l);
            check("m_tuser", m_tuser, e.u);
            check("grant_src", grant_src, e.src);
            check("frame_done", frame_done, e.done);
            check("sof_err", sof_err, e.err);
          end
          if (frame_done) begin done_at.push_back(acc_cnt); done_src.push_back(grant_src); end
          if (sof_err) err_at.push_back(acc_cnt);
        end else begin
          check("frame_done_no_beat", frame_done, 0);
          check("sof_err_no_beat", sof_err, 0);
        end
      end
    end
  end

  initial begin
    int cyc;
    sStreamReset_n = 0;
    repeat (3) @(negedge StreamClk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_grant_src", grant_src, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sof_err", sof_err, 0);
    check("rst_s0_tready", s0_tready, 0);
`ifdef ARB_STATS_EN
    check("rst_frames0", frames0, 0);
    check("rst_frames1", frames1, 0);
`endif
    @(negedge StreamClk);
    sStreamReset_n = 1;

    // Single frame from source 0
    clear_log();
    add_frame(0, 'h10, 32, 0);
    build_exp();
    repeat (3) @(negedge StreamClk);
    #2;
    check("t1_busy", busy, 1);
    check("t1_grant_src", grant_src, 0);
    wait_drain("t1");
    check("t1_beats", acc_cnt, 32);
    check("t1_done_cnt", done_at.size(), 1);
    if (done_at.size() > 0) check("t1_done_beat", done_at[0], 32);
`ifdef ARB_STATS_EN
    check("t1_frames0", frames0, 1);
`endif

    // Tie after reset, then alternating round-robin
    do_reset();
    clear_log();
    add_frame(0, 'h20, 32, 0);
    add_frame(1, 'h21, 32, 0);
    add_frame(0, 'h22, 32, 0);
    add_frame(1, 'h23, 32, 0);
    build_exp();
    wait_drain("t2");
    check("t2_done_cnt", done_at.size(), 4);
    if (done_at.size() == 4) begin
      check("t2_src0", done_src[0], 0);
      check("t2_src1", done_src[1], 1);
      check("t2_src2", done_src[2], 0);
      check("t2_src3", done_src[3], 1);
      check("t2_done_beat3", done_at[3], 128);
    end

    // Pre-SOF junk on source 1 is dropped
    clear_log();
    add_junk(1, 5);
    add_frame(1, 'h30, 32, 0);
    build_exp();
    wait_drain("t3");
    check("t3_beats", acc_cnt, 32);
    if (done_at.size() > 0) check("t3_done_beat", done_at[0], 32);

    // Sink ready toggles every cycle
    clear_log();
    ready_mode = 1;
    add_frame(0, 'h40, 32, 0);
    add_frame(1, 'h41, 32, 0);
    build_exp();
    wait_drain("t4");
    ready_mode = 0;
    check("t4_beats", acc_cnt, 64);
    check("t4_done_cnt", done_src.size(), 2);
    if (done_src.size() == 2) check("t4_first_src", done_src[0], 0);

    // Spurious SOF at beat 10 restarts the frame
    clear_log();
    add_frame(0, 'h50, 40, 10);
    build_exp();
    wait_drain("t5");
    check("t5_err_cnt", err_at.size(), 1);
    if (err_at.size() > 0) check("t5_err_beat", err_at[0], 10);
    check("t5_done_cnt", done_at.size(), 1);
    if (done_at.size() > 0) check("t5_done_beat", done_at[0], 40);

    // Asynchronous reset while beat 20 is presented
    clear_log();
    add_frame(0, 'h60, 32, 0);
    build_exp();
    cyc = 0;
    while (acc_cnt < 19 && cyc < 500) begin
      @(negedge StreamClk);
      cyc++;
    end
    check("t6_reached_beat20", acc_cnt, 19);
    #1;
    sStreamReset_n = 0;
    #1;
    check("t6_rst_m_tvalid", m_tvalid, 0);
    check("t6_rst_s0_tready", s0_tready, 0);
    check("t6_rst_s1_tready", s1_tready, 0);
    check("t6_rst_busy", busy, 0);
`ifdef ARB_STATS_EN
    check("t6_rst_frames0", frames0, 0);
`endif
    repeat (2) @(negedge StreamClk);
    sStreamReset_n = 1;
    exp_q.delete();
    m_rr_last = 1'b1;
    clear_log();
    raw0 = drv0;
    add_frame(0, 'h61, 32, 0);
    build_exp();
    wait_drain("t6");
    check("t6_beats", acc_cnt, 32);
    if (done_at.size() > 0) check("t6_done_beat", done_at[0], 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
